// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the regfile_mp register file and its clear engine.
package regfile_mp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int ZERO_ADDR = 0;

  // Low bit of slice idx in a port flattened as {..., slice1, slice0}.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_mp_clr.sv
// Sequential clear engine: zeroes every entry once after reset and on each CLR request.
module regfile_mp_clr
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              CLR,
  output logic              BUSY,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] ccnt;

  // A CLR seen while clearing restarts the sweep rather than extending it.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= CLEAR;
      ccnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CLR) begin
            state <= CLEAR;
            ccnt  <= '0;
          end
        end
        CLEAR: begin
          if (CLR) begin
            ccnt <= '0;
          end else if (ccnt == ADDR_W'(DEPTH - 1)) begin
            state <= IDLE;
            ccnt  <= '0;
          end else begin
            ccnt <= ccnt + ADDR_W'(1);
          end
        end
        default: begin
          state <= CLEAR;
          ccnt  <= '0;
        end
      endcase
    end
  end

  assign BUSY     = (state == CLEAR);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = ccnt;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with built-in clear engine.
// Optional write-through bypass on the read ports: define REGFILE_MP_BYPASS_EN.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 6,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     WR,
  input  logic [ADDR_W-1:0]        RW,
  input  logic [DATA_W-1:0]        DW,
  input  logic [N_RD*ADDR_W-1:0]   RA,
  output logic [N_RD*DATA_W-1:0]   DR,
  input  logic                     CLR,
  output logic                     BUSY,
  output logic                     WERR
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero;
  logic              wr_ok;

  regfile_mp_clr #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .CLR      (CLR),
    .BUSY     (BUSY),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_zero = (ZERO_REG != 0) && (RW == ADDR_W'(ZERO_ADDR));
  // A pending clear owns the array, so a same-cycle CLR also drops the write.
  assign wr_ok   = HRESETn && WR && !BUSY && !CLR && !wr_zero;

  always_ff @(posedge HCLK) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[RW] <= DW;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      WERR <= 1'b0;
    end else begin
      WERR <= WR && (BUSY || CLR);
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata;

    assign addr = RA[slice_lo(k, ADDR_W) +: ADDR_W];

    always_comb begin
      rdata = mem[addr];
`ifdef REGFILE_MP_BYPASS_EN
      if (WR && !BUSY && (addr == RW)) begin
        rdata = DW;
      end
`endif
      if (BUSY || ((ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR)))) begin
        rdata = '0;
      end
    end

    assign DR[slice_lo(k, DATA_W) +: DATA_W] = rdata;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file, successor to the fixed 64x64 two-read-port file.
- Width, address width and read-port count are generic. Entry 0 can optionally be hardwired to zero.
- Adds a sequential clear engine: it runs automatically after reset and on request, and reports BUSY while running.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port); also used as a clock-gating test target.

Parameters:
- DATA_W, 64, bits per entry
- ADDR_W, 6, address width; depth DEPTH = 2**ADDR_W
- N_RD, 2, number of combinational read ports (1..8)
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
- HCLK  in  1  clock, all state on rising edge
- HRESETn  in  1  synchronous active-low reset
- WR  in  1  write enable
- RW  in  ADDR_W  write address
- DW  in  DATA_W  write data
- RA  in  N_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- DR  out  N_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
- CLR  in  1  clear request (single-cycle pulse or level)
- BUSY  out  1  clear sequence in progress
- WERR  out  1  registered one-cycle pulse: a write was dropped

Behaviour:
- FSM states:
  - CLEAR: clear engine active.
  - IDLE: normal operation.
- Reset: HRESETn=0 at a clock edge sets state=CLEAR, clear counter CCNT=0, WERR=0. BUSY is 1 from the first edge after reset is sampled. Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to entry CCNT, then CCNT++.
  - When CCNT==DEPTH-1 has been written, go to IDLE next edge.
  - Sequence lasts exactly DEPTH cycles; BUSY=1 throughout, BUSY=0 on the first IDLE cycle.
- CLR handling:
  - CLR=1 in IDLE enters CLEAR next edge with CCNT=0.
  - CLR=1 while already in CLEAR restarts the sequence: CCNT=0.
- Writes in IDLE:
  - WR=1 writes DW to entry RW at the edge.
  - If ZERO_REG=1 and RW==0, the write is silently ignored; WERR is not raised.
- Writes while BUSY:
  - WR=1 is dropped and WERR=1 the next cycle.
  - Same-cycle CLR in IDLE also drops WR and raises WERR, because clear has priority.
- Reads (combinational, zero latency):
  - DR[k] = entry[RA[k]].
  - Forced to 0 when ZERO_REG=1 and RA[k]==0.
  - Forced to 0 while BUSY=1.
- Read-during-write to the same address without the optional feature: old data this cycle, new data from the next cycle.
- Reset mid-clear restarts the sequence from CCNT=0.
- Reset has priority over CLR and WR.
- Counter width is ADDR_W; no wrap beyond DEPTH-1 is observable.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: write-through bypass. When WR=1, state=IDLE and RA[k]==RW, DR[k]=DW in the same cycle. Exception: ZERO_REG=1 and RW==0 still returns 0.
- Undefined: no bypass; read-during-write returns old contents.

Decomposition:
- Shared package regfile_mp_pkg holds:
  - state enum (IDLE, CLEAR)
  - a function for slice offsets of flattened ports
  - localparam for the zero-register address (0)
- One natural sub-module: regfile_mp_clr, the clear FSM plus counter, with outputs BUSY, clr_we, clr_addr. The top level holds the storage array, write mux and read ports.

Test Plan (DATA_W=64, ADDR_W=6, N_RD=2, ZERO_REG=1):
- Reset sequence: hold HRESETn=0 for 2 cycles, then release -> BUSY=1 for exactly 64 cycles, then 0; all reads return 0 during and after the sequence.
- Write/read: WR=1, RW=5, DW=64'hDEAD_BEEF_0123_4567; next cycle RA0=5, RA1=5 -> both ports 64'hDEAD_BEEF_0123_4567.
- Zero register: WR=1, RW=0, DW=all-ones; then RA0=0 -> DR0=0 and WERR stays 0.
- Write during clear: pulse CLR, then WR=1, RW=7, DW=1 on the next cycle -> WERR=1 one cycle later; after BUSY falls, RA0=7 reads 0.
- Same-cycle read/write: RW=9, DW=3, WR=1 with RA1=9 -> without the macro DR1 shows the old value (0), with REGFILE_MP_BYPASS_EN DR1=3; both show 3 the next cycle.
- Reset mid-clear: assert HRESETn=0 at cycle 30 of a CLR sequence -> CCNT restarts at 0; BUSY stays high for a further 64 cycles after release.
